// File: rtl/two_src_mux_arbiter_pkg.sv
// Shared types and constants for the two-source round-robin, packet-locked arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  // Source encoding doubles as the 2:1 mux select value.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/two_src_mux_arbiter_if.sv
// Stream bundle for the arbiter: sources A and B in, registered Z out,
// plus the source tag S and the optional beat counters.
interface two_src_mux_arbiter_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic             A_VALID;
  logic [WIDTH-1:0] A_DATA;
  logic             A_LAST;
  logic             A_READY;
  logic             B_VALID;
  logic [WIDTH-1:0] B_DATA;
  logic             B_LAST;
  logic             B_READY;
  logic             Z_VALID;
  logic [WIDTH-1:0] Z_DATA;
  logic             Z_LAST;
  logic             Z_READY;
  logic             S;
  logic [CNT_WIDTH-1:0] CNT_A;
  logic [CNT_WIDTH-1:0] CNT_B;

  modport slave (
    input  A_VALID, A_DATA, A_LAST,
    output A_READY,
    input  B_VALID, B_DATA, B_LAST,
    output B_READY,
    output Z_VALID, Z_DATA, Z_LAST, S,
    input  Z_READY,
    output CNT_A, CNT_B
  );

  modport master (
    output A_VALID, A_DATA, A_LAST,
    input  A_READY,
    output B_VALID, B_DATA, B_LAST,
    input  B_READY,
    input  Z_VALID, Z_DATA, Z_LAST, S,
    output Z_READY,
    input  CNT_A, CNT_B
  );

endinterface

// File: rtl/two_src_mux_arbiter_stream_out_reg.sv
// One-entry output register: loads an accepted beat, clears valid when drained.
module stream_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] data_in,
  input  logic             last_in,
  input  logic             src_in,
  output logic             vld_p1,
  output logic [WIDTH-1:0] data_p1,
  output logic             last_p1,
  output logic             src_p1
);

  // Load wins over drain so a simultaneous drain+accept keeps valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      src_p1  <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_in;
      last_p1 <= last_in;
      src_p1  <= src_in;
    end else if (drain) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: rtl/two_src_mux_arbiter.sv
// Round-robin, packet-locked 2:1 stream arbiter with a registered output.
// Optional feature: define MUX_ARB_STATS_EN to build saturating per-source
// beat counters on CNT_A/CNT_B; otherwise both are tied to zero.
module two_src_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input logic              CLK,
  input logic              RST_N,
  two_src_mux_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic             gnt_vld, gnt_src;
  logic             sel_valid, sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             out_free, accept;
  logic             z_vld_p1, z_last_p1, z_src_p1;
  logic [WIDTH-1:0] z_data_p1;

  // State register; reset leaves last_gnt at B so A wins the first tie.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      last_gnt_q <= SRC_B;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Grant selection, source mux, readies and next-state.
  always_comb begin
    gnt_vld    = 1'b0;
    gnt_src    = SRC_A;
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      LOCK_A: begin
        gnt_vld = 1'b1;
        gnt_src = SRC_A;
      end
      LOCK_B: begin
        gnt_vld = 1'b1;
        gnt_src = SRC_B;
      end
      default: begin
        if (bus.A_VALID && (!bus.B_VALID || last_gnt_q == SRC_B)) begin
          gnt_vld = 1'b1;
          gnt_src = SRC_A;
        end else if (bus.B_VALID) begin
          gnt_vld = 1'b1;
          gnt_src = SRC_B;
        end
      end
    endcase

    sel_valid = (gnt_src == SRC_B) ? bus.B_VALID : bus.A_VALID;
    sel_data  = (gnt_src == SRC_B) ? bus.B_DATA  : bus.A_DATA;
    sel_last  = (gnt_src == SRC_B) ? bus.B_LAST  : bus.A_LAST;
    out_free  = !z_vld_p1 || bus.Z_READY;
    accept    = RST_N && gnt_vld && sel_valid && out_free;

    if (accept) begin
      last_gnt_d = gnt_src;
      if (sel_last)
        state_d = IDLE;
      else
        state_d = (gnt_src == SRC_B) ? LOCK_B : LOCK_A;
    end
  end

  assign bus.A_READY = RST_N && gnt_vld && (gnt_src == SRC_A) && out_free;
  assign bus.B_READY = RST_N && gnt_vld && (gnt_src == SRC_B) && out_free;

  // ---- stage p1: registered output beat ----
  stream_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk     (CLK),
    .rst_n   (RST_N),
    .load    (accept),
    .drain   (bus.Z_READY),
    .data_in (sel_data),
    .last_in (sel_last),
    .src_in  (gnt_src),
    .vld_p1  (z_vld_p1),
    .data_p1 (z_data_p1),
    .last_p1 (z_last_p1),
    .src_p1  (z_src_p1)
  );

  assign bus.Z_VALID = z_vld_p1;
  assign bus.Z_DATA  = z_data_p1;
  assign bus.Z_LAST  = z_last_p1;
  assign bus.S       = z_src_p1;

`ifdef MUX_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_b_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Per-source accepted-beat counters, saturating at all-ones.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (accept) begin
      if (gnt_src == SRC_A) cnt_a_q <= sat_inc(cnt_a_q);
      else                  cnt_b_q <= sat_inc(cnt_b_q);
    end
  end

  assign bus.CNT_A = cnt_a_q;
  assign bus.CNT_B = cnt_b_q;
`else
  assign bus.CNT_A = '0;
  assign bus.CNT_B = '0;
`endif

endmodule

// File: tb/tb_two_src_mux_arbiter.sv
// Scoreboard bench for two_src_mux_arbiter: randomized packet sources, a
// packet-level arbitration model, and an expected-beat queue for Z.
module tb_two_src_mux_arbiter;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;
  localparam int CMAX      = (1 << CNT_WIDTH) - 1;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  two_src_mux_arbiter_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  two_src_mux_arbiter #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
    logic             s;
  } beat_t;

  int checks = 0;
  int failures = 0;

  // Scoreboard / reference model state (written only by the monitor)
  beat_t expq[$];
  beat_t z_hold;
  bit    lock_on, lock_src, last_g;
  int    cnt_m[2];
  bit    hs[2];
  int    zhs_cnt;

  // Source driver state (written only by the stimulus process)
  bit               en[2];
  int               vpct[2];
  int               plen_mode[2];
  logic [WIDTH-1:0] seq[2];
  logic [WIDTH-1:0] base[2];
  int               bidx[2];
  int               plen[2];
  bit               dv[2];
  logic [WIDTH-1:0] dd[2];
  bit               dl[2];
  int               zr_pct;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: evaluates the cycle just before the rising edge and predicts its effect
  bit   m_zv, m_gv, m_g, m_free, m_ea, m_eb, m_acc;
  beat_t m_b, m_pop;
  always @(negedge CLK) begin
    m_zv = (expq.size() > 0);
    chk("z_valid", bus.Z_VALID, m_zv);
    chk("z_data_hold", bus.Z_DATA, z_hold.d);
    chk("z_last_hold", bus.Z_LAST, z_hold.l);
    chk("s_hold", bus.S, z_hold.s);
`ifdef MUX_ARB_STATS_EN
    chk("cnt_a", bus.CNT_A, cnt_m[0]);
    chk("cnt_b", bus.CNT_B, cnt_m[1]);
`else
    chk("cnt_a_off", bus.CNT_A, 0);
    chk("cnt_b_off", bus.CNT_B, 0);
`endif
    if (lock_on) begin
      m_gv = 1'b1; m_g = lock_src;
    end else if (bus.A_VALID && (!bus.B_VALID || last_g)) begin
      m_gv = 1'b1; m_g = 1'b0;
    end else if (bus.B_VALID) begin
      m_gv = 1'b1; m_g = 1'b1;
    end else begin
      m_gv = 1'b0; m_g = 1'b0;
    end
    m_free = !m_zv || bus.Z_READY;
    m_ea = RST_N && m_gv && !m_g && m_free;
    m_eb = RST_N && m_gv &&  m_g && m_free;
    chk("a_ready", bus.A_READY, m_ea);
    chk("b_ready", bus.B_READY, m_eb);
    hs[0] = 1'b0;
    hs[1] = 1'b0;
    if (!RST_N) begin
      expq.delete();
      z_hold = '{d: '0, l: 1'b0, s: 1'b0};
      lock_on = 1'b0; lock_src = 1'b0; last_g = 1'b1;
      cnt_m[0] = 0; cnt_m[1] = 0;
    end else begin
      if (m_zv && bus.Z_READY) begin
        m_pop = expq.pop_front();
        chk("z_out_data", bus.Z_DATA, m_pop.d);
        chk("z_out_last", bus.Z_LAST, m_pop.l);
        chk("z_out_src", bus.S, m_pop.s);
        zhs_cnt++;
      end
      m_acc = m_gv && (m_g ? bus.B_VALID : bus.A_VALID) && m_free;
      if (m_acc) begin
        m_b.d = m_g ? bus.B_DATA : bus.A_DATA;
        m_b.l = m_g ? bus.B_LAST : bus.A_LAST;
        m_b.s = m_g;
        expq.push_back(m_b);
        z_hold = m_b;
        last_g = m_g;
        lock_on = !m_b.l;
        lock_src = m_g;
        if (cnt_m[m_g] < CMAX) cnt_m[m_g]++;
        hs[m_g] = 1'b1;
      end
    end
  end

  task automatic apply();
    bus.A_VALID = dv[0]; bus.A_DATA = dd[0]; bus.A_LAST = dl[0];
    bus.B_VALID = dv[1]; bus.B_DATA = dd[1]; bus.B_LAST = dl[1];
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (hs[s]) begin
        dv[s] = 1'b0;
        seq[s] = seq[s] + 1'b1;
        bidx[s] = dl[s] ? 0 : bidx[s] + 1;
      end
      if (!dv[s] && en[s] && ($urandom_range(99) < vpct[s])) begin
        if (bidx[s] == 0)
          plen[s] = (plen_mode[s] == 0) ? int'($urandom_range(4, 1)) : plen_mode[s];
        dv[s] = 1'b1;
        dd[s] = base[s] + seq[s];
        dl[s] = (bidx[s] == plen[s] - 1);
      end
    end
    apply();
    bus.Z_READY = ($urandom_range(99) < zr_pct);
  endtask

  task automatic do_reset(input int n);
    RST_N = 1'b0;
    repeat (n) step();
    RST_N = 1'b1;
    for (int s = 0; s < 2; s++) begin
      dv[s] = 1'b0; bidx[s] = 0;
    end
    apply();
  endtask

  task automatic set_src(input int s, input bit e, input int pct, input int mode);
    en[s] = e; vpct[s] = pct; plen_mode[s] = mode;
  endtask

  int c0;
  bit seen;

  initial begin
    base[0] = 8'hA0; base[1] = 8'hB0;
    seq[0] = '0; seq[1] = '0;
    for (int s = 0; s < 2; s++) begin
      bidx[s] = 0; plen[s] = 1; dd[s] = base[s]; dl[s] = 1'b1; dv[s] = 1'b1;
    end
    set_src(0, 1, 100, 1);
    set_src(1, 1, 100, 1);
    zr_pct = 100;
    bus.Z_READY = 1'b1;
    apply();
    lock_on = 1'b0; lock_src = 1'b0; last_g = 1'b1;
    z_hold = '{d: '0, l: 1'b0, s: 1'b0};
    zhs_cnt = 0;

    // Reset held 2 cycles with both sources valid
    RST_N = 1'b0;
    repeat (2) step();
    chk("rst_z_valid", bus.Z_VALID, 0);
    chk("rst_s", bus.S, 0);
    chk("rst_a_ready", bus.A_READY, 0);
    chk("rst_b_ready", bus.B_READY, 0);
    chk("rst_cnt_a", bus.CNT_A, 0);
    RST_N = 1'b1;

    // Tie: single-beat packets on both, full throughput, strict alternation
    c0 = zhs_cnt;
    repeat (20) step();
    chk("tie_throughput", (zhs_cnt - c0) >= 18, 1);

    // Lock: 3-beat A packet against a permanently valid B
    do_reset(1);
    set_src(0, 1, 100, 3);
    set_src(1, 1, 100, 1);
    repeat (10) step();

    // Backpressure: Z stalled 4 cycles, then released
    zr_pct = 0;
    repeat (4) step();
    chk("bp_a_ready", bus.A_READY, 0);
    chk("bp_b_ready", bus.B_READY, 0);
    zr_pct = 100;
    repeat (4) step();

    // Random traffic with random packet lengths and backpressure
    set_src(0, 1, 60, 0);
    set_src(1, 1, 60, 0);
    zr_pct = 70;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1);
      step();
    end

    // Reset in the middle of a 4-beat B packet
    zr_pct = 100;
    do_reset(1);
    set_src(0, 0, 0, 1);
    set_src(1, 1, 100, 4);
    for (int i = 0; i < 20 && bidx[1] != 2; i++) step();
    chk("midpkt_reached", bidx[1], 2);
    set_src(0, 1, 100, 1);
    do_reset(1);
    chk("midpkt_z_dropped", bus.Z_VALID, 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus.Z_VALID) begin
        seen = 1'b1;
        chk("midpkt_first_src", bus.S, 0);
      end
    end
    chk("midpkt_z_seen", seen, 1);

    // Counter saturation: 20+ A beats only
    do_reset(1);
    set_src(0, 1, 100, 1);
    set_src(1, 0, 0, 1);
    zr_pct = 100;
    repeat (25) step();
`ifdef MUX_ARB_STATS_EN
    chk("cnt_a_sat", bus.CNT_A, CMAX);
`else
    chk("cnt_a_off_final", bus.CNT_A, 0);
`endif
    chk("cnt_b_final", bus.CNT_B, 0);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
